// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer between the UART receive engine and the processor.
//   Each completed character {status, data} is captured from the engine. A registered
//   one-cycle rx_read acknowledge then clears the engine's RXRDY. Captured characters
//   are queued in a circular FIFO that the processor reads with first-word fall-through.
//   When the FIFO is full the engine is not acknowledged. It keeps RXRDY asserted, and
//   its own OVF status flags any overrun that follows.
// Parameters:
//   DEPTH      number of entries (power of two, >= 2)
//   AW         log2(DEPTH); pointer width, count is AW+1 bits
// Ports:
//   clk        system clock, all state on posedge
//   rst        asynchronous active-high reset
//   rx_rdy     engine has a character waiting
//   rx_data    engine character data
//   rx_status  engine status {OVF, FERR, PERR}
//   rx_read    registered one-cycle acknowledge to the engine
//   cpu_rd     processor pop strobe (one cycle per pop)
//   cpu_data   head entry data
//   cpu_status head entry status
//   empty      count == 0
//   full       count == DEPTH
//   count      entries held, 0..DEPTH
// Optional feature (macro RX_FIFO_IRQ_EN):
//   irq_level  threshold input; rx_irq is a registered level interrupt that is set
//              when irq_level != 0 and count >= irq_level.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_rdy,
  input  logic [7:0]    rx_data,
  input  logic [2:0]    rx_status,
  output logic          rx_read,
  input  logic          cpu_rd,
  output logic [7:0]    cpu_data,
  output logic [2:0]    cpu_status,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
`ifdef RX_FIFO_IRQ_EN
  ,
  input  logic [AW:0]   irq_level,
  output logic          rx_irq
`endif
);

  typedef enum logic [0:0] {StIdle, StAck} state_e;

  state_e        state_q, state_d;
  logic          rx_read_q, rx_read_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;

  // Entry layout: {status[2:0], data[7:0]}
  logic [10:0]   mem_q [DEPTH];

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));

  // Capture FSM. A push while full is allowed only when a pop frees the slot on the
  // same edge. In StAck the engine is still clearing RXRDY, so rx_rdy is ignored there.
  always_comb begin
    state_d   = state_q;
    rx_read_d = 1'b0;
    push      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rx_rdy && (!full || cpu_rd)) begin
          push      = 1'b1;
          rx_read_d = 1'b1;
          state_d   = StAck;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    pop      = cpu_rd && !empty;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      rx_read_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      rx_read_q <= rx_read_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {rx_status, rx_data};
    end
  end

  assign rx_read    = rx_read_q;
  assign count      = count_q;
  assign cpu_data   = mem_q[rd_ptr_q][7:0];
  assign cpu_status = mem_q[rd_ptr_q][10:8];

`ifdef RX_FIFO_IRQ_EN
  logic rx_irq_q, rx_irq_d;

  // Driven from the registered count, so rx_irq follows one clock after count changes.
  always_comb begin
    rx_irq_d = (irq_level != '0) && (count_q >= irq_level);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_irq_q <= 1'b0;
    end else begin
      rx_irq_q <= rx_irq_d;
    end
  end

  assign rx_irq = rx_irq_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [2:0]  rx_status = 3'b000;
  logic        rx_read;
  logic        cpu_rd = 1'b0;
  logic [7:0]  cpu_data;
  logic [2:0]  cpu_status;
  logic        empty;
  logic        full;
  logic [AW:0] count;
`ifdef RX_FIFO_IRQ_EN
  logic [AW:0] irq_level = '0;
  logic        rx_irq;
`endif

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .rx_status  (rx_status),
    .rx_read    (rx_read),
    .cpu_rd     (cpu_rd),
    .cpu_data   (cpu_data),
    .cpu_status (cpu_status),
    .empty      (empty),
    .full       (full),
    .count      (count)
`ifdef RX_FIFO_IRQ_EN
    ,
    .irq_level  (irq_level),
    .rx_irq     (rx_irq)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Characters waiting to be offered by the engine, and the expected FIFO contents.
  logic [10:0] tx_q[$];
  logic [10:0] sb_q[$];

  // Engine model: holds RXRDY with a character until acknowledged, keeps it high
  // through the ack cycle, then drops it or offers the next character.
  logic        busy = 1'b0;
  logic        acked = 1'b0;
  int          wait_cnt = 0;
  logic [10:0] cur;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      acked = 1'b0;
    end else if (busy) begin
      if (rx_read) begin
        acked = 1'b1;
      end else if (acked) begin
        busy   = 1'b0;
        acked  = 1'b0;
        rx_rdy = 1'b0;
      end else begin
        wait_cnt++;
        if (wait_cnt > 3000) begin
          checks++;
          errors++;
          $display("FAIL engine_wait: no rx_read after %0d cycles, required within 3000", wait_cnt);
          busy   = 1'b0;
          rx_rdy = 1'b0;
        end
      end
    end
    if (!busy && !rst && tx_q.size() > 0) begin
      cur = tx_q.pop_front();
      {rx_status, rx_data} = cur;
      rx_rdy   = 1'b1;
      busy     = 1'b1;
      wait_cnt = 0;
    end
  end

  // Reference model + monitor. At each negedge the outputs reflect the last edge and
  // the inputs are those the next edge will sample.
  logic        mon_en = 1'b0;
  logic        exp_ack = 1'b0;
  logic        pend_v = 1'b0;
  logic [10:0] pend;
  logic        m_pop, m_cap;
  int          m_sz;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (pend_v) begin
        sb_q.push_back(pend);
        pend_v = 1'b0;
      end
      check("rx_read", rx_read, exp_ack);
      m_sz = sb_q.size();
      check("count", count, m_sz);
      check("empty", empty, m_sz == 0);
      check("full", full, m_sz == DEPTH);
      m_pop = cpu_rd && (m_sz > 0);
      if (m_pop) begin
        check("head", {cpu_status, cpu_data}, sb_q[0]);
        void'(sb_q.pop_front());
      end
      m_cap = rx_rdy && !exp_ack && ((m_sz < DEPTH) || m_pop);
      if (m_cap) begin
        pend   = {rx_status, rx_data};
        pend_v = 1'b1;
      end
      exp_ack = m_cap;
    end
  end

  task automatic send(input logic [7:0] d, input logic [2:0] s);
    tx_q.push_back({s, d});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((tx_q.size() != 0 || busy || rx_read) && n < 400) begin
      cyc(1);
      n++;
    end
    check("idle_timeout", n < 400, 1);
  endtask

  task automatic drain();
    int n = 0;
    @(posedge clk);
    #1;
    cpu_rd = 1'b1;
    while ((sb_q.size() != 0 || pend_v || count != 0 || tx_q.size() != 0 || busy) && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    cpu_rd = 1'b0;
    check("drain_timeout", n < 600, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset state
    cyc(3);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_rx_read", rx_read, 0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Single character
    send(8'hA5, 3'b000);
    wait_idle();
    check("single_count", count, 1);
    check("single_empty", empty, 0);
    check("single_data", cpu_data, 8'hA5);
    check("single_status", cpu_status, 3'b000);
    @(posedge clk); #1; cpu_rd = 1'b1;
    @(posedge clk); #1; cpu_rd = 1'b0;
    #1;
    check("single_pop_empty", empty, 1);

    // Ordering with status
    send(8'h01, 3'b010);
    send(8'h02, 3'b001);
    send(8'h03, 3'b000);
    wait_idle();
    check("order_count", count, 3);
    check("order_head", {cpu_status, cpu_data}, {3'b010, 8'h01});
    drain();

    // Fill, blocked 17th, pop frees slot and 17th captured on same edge, wrap
    for (int i = 0; i < 17; i++) send(8'h40 + 8'(i), 3'(i));
    cyc(40);
    check("fill_full", full, 1);
    check("fill_count", count, DEPTH);
    check("fill_blocked_ack", rx_read, 0);
    check("fill_rx_rdy_held", rx_rdy, 1);
    cpu_rd = 1'b1;
    cyc(1);
    cpu_rd = 1'b0;
    check("fill_swap_count", count, DEPTH);
    check("fill_swap_ack", rx_read, 1);
    drain();

    // Simultaneous push and pop at count 5
    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), 3'b100);
    wait_idle();
    check("simul_pre_count", count, 5);
    send(8'hC3, 3'b101);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!(rx_rdy && !rx_read) && n < 20);
    check("simul_wait", n < 20, 1);
    cpu_rd = 1'b1;
    cyc(1);
    cpu_rd = 1'b0;
    check("simul_count", count, 5);
    check("simul_head", cpu_data, 8'h11);
    drain();

    // Pop while empty is ignored
    cpu_rd = 1'b1;
    cyc(3);
    cpu_rd = 1'b0;
    check("empty_pop_count", count, 0);
    check("empty_pop_empty", empty, 1);

    // Asynchronous reset mid-operation, then re-capture of the still-pending character
    for (int i = 0; i < 7; i++) send(8'h70 + 8'(i), 3'b011);
    n = 0;
    while (!(count == 7 && rx_read) && n < 100) begin
      cyc(1);
      n++;
    end
    check("rst_mid_wait", n < 100, 1);
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    check("rst_mid_count", count, 0);
    check("rst_mid_rx_read", rx_read, 0);
    check("rst_mid_empty", empty, 1);
    cyc(2);
    sb_q.delete();
    pend_v  = 1'b0;
    exp_ack = 1'b0;
    rst     = 1'b0;
    mon_en  = 1'b1;
    wait_idle();
    check("recapture_count", count, 1);
    check("recapture_data", {cpu_status, cpu_data}, {3'b011, 8'h76});
    drain();

`ifdef RX_FIFO_IRQ_EN
    irq_level = 5'd4;
    for (int i = 0; i < 4; i++) send(8'h20 + 8'(i), 3'b000);
    wait_idle();
    check("irq_set", rx_irq, 1);
    cpu_rd = 1'b1;
    cyc(1);
    cpu_rd = 1'b0;
    cyc(1);
    check("irq_clear", rx_irq, 0);
    irq_level = 5'd0;
    send(8'h2F, 3'b000);
    wait_idle();
    cyc(1);
    check("irq_disabled", rx_irq, 0);
    drain();
`endif

    // Randomized traffic: slow reader (builds up to full), then fast reader
    for (int ph = 0; ph < 2; ph++) begin
      repeat (200) begin
        @(posedge clk);
        #1;
        cpu_rd = (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
        if (tx_q.size() < 3 && $urandom_range(0, 1) == 1)
          send(8'($urandom), 3'($urandom));
      end
    end
    cpu_rd = 1'b0;
    drain();
    check("final_empty", empty, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
